joybus_tx: RTL and testbench

- Console-side Joybus transmitter. It serialises a 1-3 byte command onto the single-wire Joybus line using the pulse-width bit encoding that joybus_rx decodes, and terminates the frame with a stop bit.
- It sits beside joybus_rx in the controller interface. The host controller FSM issues tx_start, waits for tx_done, then fires rx_start to collect the reply.

---
 rtl/joybus_pkg.sv | 21 ++
 rtl/joybus_symbol_gen.sv | 101 ++++++++++
 rtl/joybus_tx.sv | 105 ++++++++++
 tb/tb_joybus_tx.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/joybus_pkg.sv
// Shared Joybus definitions for the transmitter and receiver.
//   - bit-cell timing in microseconds
//   - transmitter state and symbol encodings
//   - command byte values
package joybus_pkg;

    localparam int BIT_US   = 4;
    localparam int SHORT_US = 1;
    localparam int LONG_US  = 3;

    localparam logic [7:0] CMD_STATUS = 8'h00;
    localparam logic [7:0] CMD_POLL   = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam logic [7:0] CMD_WRITE  = 8'h03;
    localparam logic [7:0] CMD_RESET  = 8'hFF;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, STOP} tx_state_e;

    typedef enum logic [1:0] {SYM_ZERO, SYM_ONE, SYM_STOP} sym_e;

endpackage

// File: rtl/joybus_symbol_gen.sv
// Joybus symbol waveform generator.
//   clk, rst  : clock, synchronous active-high reset
//   go, sym   : launch a ZERO, ONE or STOP symbol; accepted when idle or
//               in the last cycle of the current symbol (back-to-back)
//   tx_line   : registered line level, 1 = released, 0 = driven low
//   sym_done  : high in the last cycle of a symbol
//
// state | meaning
// IDLE  | line released, waiting for go
// LOW   | low part of a data bit
// HIGH  | high part of a data bit
// STOP  | low part of the stop bit
module joybus_symbol_gen
    import joybus_pkg::*;
#(
    parameter int US_CYCLES   = 25,
    parameter int STOP_LOW_US = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    input  sym_e sym,
    output logic tx_line,
    output logic sym_done
);

    localparam int CW = $clog2(BIT_US * US_CYCLES);
    localparam logic [CW-1:0] SHORT_END = CW'(SHORT_US * US_CYCLES - 1);
    localparam logic [CW-1:0] LONG_END  = CW'(LONG_US * US_CYCLES - 1);
    localparam logic [CW-1:0] STOP_END  = CW'(STOP_LOW_US * US_CYCLES - 1);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    sym_e          sym_q, sym_d;
    logic          line_q, line_d;
    logic [CW-1:0] low_end, high_end;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        sym_d    = sym_q;
        sym_done = 1'b0;
        low_end  = (sym_q == SYM_ONE) ? SHORT_END : LONG_END;
        high_end = (sym_q == SYM_ONE) ? LONG_END : SHORT_END;

        case (state_q)
            IDLE: cnt_d = '0;
            LOW: begin
                if (cnt_q == low_end) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end
            end
            HIGH: begin
                if (cnt_q == high_end) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    sym_done = 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == STOP_END) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    sym_done = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A go in the final cycle of a symbol chains the next one with no gap.
        if (go && (state_q == IDLE || sym_done)) begin
            state_d = (sym == SYM_STOP) ? STOP : LOW;
            sym_d   = sym;
            cnt_d   = '0;
        end

        // Line is registered from the next state so it tracks state_q exactly.
        line_d = !(state_d == LOW || state_d == STOP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sym_q   <= SYM_ZERO;
            line_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sym_q   <= sym_d;
            line_q  <= line_d;
        end
    end

    assign tx_line = line_q;

endmodule

// File: rtl/joybus_tx.sv
// Console-side Joybus transmitter: serialises 1-3 command bytes MSB first
// followed by a stop bit.
//   clk, rst  : clock, synchronous active-high reset
//   tx_start  : one-cycle request, samples tx_len and tx_data
//   tx_len    : byte count 1..3 (0 is ignored)
//   tx_data   : bytes, tx_data[23:16] sent first
//   JB_TX     : registered line level, 1 = released
//   tx_busy   : frame in progress
//   tx_done   : one-cycle pulse as the line is released after the stop bit
module joybus_tx
    import joybus_pkg::*;
#(
    parameter int US_CYCLES   = 25,
    parameter int STOP_LOW_US = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_start,
    input  logic [1:0]  tx_len,
    input  logic [23:0] tx_data,
    output logic        JB_TX,
    output logic        tx_busy,
    output logic        tx_done
);

    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        start_q, start_d;
    logic [23:0] sr_q, sr_d;
    logic [4:0]  bits_left_q, bits_left_d;
    logic        accept;
    logic        go;
    sym_e        sym;
    logic        sym_done;

    always_comb begin
        busy_d      = busy_q;
        done_d      = 1'b0;
        start_d     = 1'b0;
        sr_d        = sr_q;
        bits_left_d = bits_left_q;
        go          = 1'b0;
        sym         = sr_q[23] ? SYM_ONE : SYM_ZERO;

        // done_q blocks a start in the tx_done cycle itself.
        accept = tx_start && !busy_q && !done_q && (tx_len != 2'd0);

        if (accept) begin
            busy_d      = 1'b1;
            start_d     = 1'b1;
            sr_d        = tx_data;
            bits_left_d = {tx_len, 3'b000};
        end

        // start_q delays the first symbol by one cycle after acceptance.
        if (start_q) begin
            go = 1'b1;
        end else if (sym_done) begin
            if (bits_left_q != 5'd0) begin
                go          = 1'b1;
                sr_d        = {sr_q[22:0], 1'b0};
                bits_left_d = bits_left_q - 5'd1;
                if (bits_left_q == 5'd1)
                    sym = SYM_STOP;
                else
                    sym = sr_q[22] ? SYM_ONE : SYM_ZERO;
            end else begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            start_q     <= 1'b0;
            sr_q        <= '0;
            bits_left_q <= '0;
        end else begin
            busy_q      <= busy_d;
            done_q      <= done_d;
            start_q     <= start_d;
            sr_q        <= sr_d;
            bits_left_q <= bits_left_d;
        end
    end

    joybus_symbol_gen #(
        .US_CYCLES   (US_CYCLES),
        .STOP_LOW_US (STOP_LOW_US)
    ) u_symbol_gen (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .sym      (sym),
        .tx_line  (JB_TX),
        .sym_done (sym_done)
    );

    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_joybus_tx.sv
module tb_joybus_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic [1:0]  len0 = '0, len1 = '0;
    logic [23:0] data0 = '0, data1 = '0;
    logic        jb0, jb1, busy0, busy1, done0, done1;

    always #20 clk = ~clk;

    joybus_tx #(.US_CYCLES(25), .STOP_LOW_US(1)) dut (
        .clk(clk), .rst(rst), .tx_start(start0), .tx_len(len0), .tx_data(data0),
        .JB_TX(jb0), .tx_busy(busy0), .tx_done(done0)
    );

    joybus_tx #(.US_CYCLES(25), .STOP_LOW_US(2)) dut_stop2 (
        .clk(clk), .rst(rst), .tx_start(start1), .tx_len(len1), .tx_data(data1),
        .JB_TX(jb1), .tx_busy(busy1), .tx_done(done1)
    );

    typedef struct {
        int          len;
        logic [23:0] data;
        int          stop_us;
    } frame_t;

    frame_t q0[$];
    frame_t q1[$];
    int total = 0;
    int bad = 0;
    int pushed = 0;
    int seen = 0;
    bit mon_en0 = 1'b1;
    bit mon_en1 = 1'b1;

    function automatic logic jb(input int sel);
        return (sel == 0) ? jb0 : jb1;
    endfunction
    function automatic logic busy(input int sel);
        return (sel == 0) ? busy0 : busy1;
    endfunction
    function automatic logic done(input int sel);
        return (sel == 0) ? done0 : done1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int sel, input int len, input logic [23:0] data);
        frame_t f;
        f.len = len;
        f.data = data;
        f.stop_us = (sel == 0) ? 1 : 2;
        if (sel == 0) q0.push_back(f);
        else q1.push_back(f);
        pushed++;
    endtask

    // Drive a one-cycle start; returns at the negedge after the sampling edge.
    task automatic send(input int sel, input int len, input logic [23:0] data, input bit push);
        if (sel == 0) begin
            start0 = 1'b1; len0 = 2'(len); data0 = data;
        end else begin
            start1 = 1'b1; len1 = 2'(len); data1 = data;
        end
        if (push) push_exp(sel, len, data);
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input int sel);
        int n = 0;
        while (!done(sel) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", int'(done(sel)), 1);
    endtask

    task automatic measure_run(input int sel, input logic level, output int n, output int herr);
        n = 0;
        herr = 0;
        while (jb(sel) === level && n < 600) begin
            if (busy(sel) !== 1'b1 || done(sel) !== 1'b0) herr++;
            n++;
            @(negedge clk);
        end
    endtask

    // Entered on the first low sample of a frame.
    task automatic run_frame(input int sel);
        frame_t e;
        int t = 0, word = 0, terr = 0, hs = 0, n, h, lo_exp;
        if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
            check("unexpected_frame", 1, 0);
            return;
        end
        e = (sel == 0) ? q0.pop_front() : q1.pop_front();
        seen++;
        for (int b = 0; b < 8 * e.len; b++) begin
            lo_exp = e.data[23 - b] ? 25 : 75;
            measure_run(sel, 1'b0, n, h);
            hs += h; t += n;
            word = (word << 1) | ((n < 50) ? 1 : 0);
            if (n != lo_exp) terr++;
            measure_run(sel, 1'b1, n, h);
            hs += h; t += n;
            if (n != 100 - lo_exp) terr++;
        end
        check("bit_timing", terr, 0);
        measure_run(sel, 1'b0, n, h);
        hs += h; t += n;
        check("stop_low", n, 25 * e.stop_us);
        check("done_at_release", int'(done(sel)), 1);
        check("busy_drop", int'(busy(sel)), 0);
        check("frame_len", t, 800 * e.len + 25 * e.stop_us);
        check("decoded", word, int'(e.data) >> (24 - 8 * e.len));
        check("busy_during_frame", hs, 0);
    endtask

    task automatic monitor(input int sel);
        forever begin
            @(negedge clk);
            if (jb(sel) === 1'b0 && ((sel == 0) ? mon_en0 : mon_en1)) run_frame(sel);
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        int errs;
        int offs [2] = '{300, 380};
        int lvls [2] = '{0, 1};
        int gap, len;
        logic [23:0] data;

        repeat (3) @(negedge clk);
        check("reset_jb", int'(jb0), 1);
        check("reset_busy", int'(busy0), 0);
        check("reset_done", int'(done0), 0);
        check("reset_jb_stop2", int'(jb1), 1);
        rst = 1'b0;
        @(negedge clk);

        // 8'h01 frame with a spurious start at cycle 400
        send(0, 1, 24'h010000, 1'b1);
        check("busy_after_start", int'(busy0), 1);
        check("latency_still_high", int'(jb0), 1);
        @(negedge clk);
        check("latency_low", int'(jb0), 0);
        repeat (399) @(negedge clk);
        send(0, 3, 24'hABCDEF, 1'b0);
        wait_done(0);

        // start held across the tx_done cycle: first edge ignored, second accepted
        start0 = 1'b1; len0 = 2'd3; data0 = 24'h028001;
        @(negedge clk);
        check("start_on_done_ignored", int'(busy0), 0);
        push_exp(0, 3, 24'h028001);
        @(negedge clk);
        start0 = 1'b0;
        check("start_after_done", int'(busy0), 1);
        wait_done(0);

        // tx_len == 0
        @(negedge clk);
        send(0, 0, 24'hFFFFFF, 1'b0);
        errs = 0;
        for (int i = 0; i < 1000; i++) begin
            if (jb0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) errs++;
            @(negedge clk);
        end
        check("len0_ignored", errs, 0);

        // reset mid-frame, once with the line low and once high
        mon_en0 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            send(0, 1, 24'h000000, 1'b0);
            @(negedge clk);
            repeat (offs[k]) @(negedge clk);
            check("abort_level", int'(jb0), lvls[k]);
            rst = 1'b1;
            @(negedge clk);
            check("abort_jb", int'(jb0), 1);
            check("abort_busy", int'(busy0), 0);
            rst = 1'b0;
            errs = 0;
            for (int i = 0; i < 200; i++) begin
                if (done0 !== 1'b0 || jb0 !== 1'b1) errs++;
                @(negedge clk);
            end
            check("abort_no_done", errs, 0);
        end
        mon_en0 = 1'b1;
        send(0, 1, 24'hFF0000, 1'b1);
        wait_done(0);

        // two-microsecond stop bit build
        send(1, 1, 24'h000000, 1'b1);
        wait_done(1);

        // randomized frames, some with spurious starts and back-to-back restarts
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 20);
            repeat (gap) @(negedge clk);
            len = $urandom_range(1, 3);
            data = 24'($urandom);
            send(0, len, data, 1'b1);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 700)) @(negedge clk);
                send(0, $urandom_range(0, 3), 24'($urandom), 1'b0);
            end
            wait_done(0);
        end

        repeat (5) @(negedge clk);
        check("frames_seen", seen, pushed);
        check("queue0_empty", q0.size(), 0);
        check("queue1_empty", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
